// File: rtl/dmem_arbiter_if.sv
// Signal bundle between dmem_arbiter, its two requesters (core C, debug D)
// and the shared data memory. The arbiter uses the slave view; the
// requesters/memory side uses the master view.
interface dmem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    // Core port
    logic          c_req;
    logic          c_we;
    logic [AW-1:0] c_addr;
    logic [DW-1:0] c_wdata;
    logic [DW-1:0] c_rdata;
    logic          c_ack;
    logic          c_stall;
    // Debug / loader port
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_ack;
    // Memory port
    logic          m_en;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata;
    // Status
    logic          busy;
    logic          owner;

    modport slave (
        input  c_req, c_we, c_addr, c_wdata,
        output c_rdata, c_ack, c_stall,
        input  d_req, d_we, d_addr, d_wdata,
        output d_rdata, d_ack,
        output m_en, m_we, m_addr, m_wdata,
        input  m_rdata,
        output busy, owner
    );

    modport master (
        output c_req, c_we, c_addr, c_wdata,
        input  c_rdata, c_ack, c_stall,
        output d_req, d_we, d_addr, d_wdata,
        input  d_rdata, d_ack,
        input  m_en, m_we, m_addr, m_wdata,
        output m_rdata,
        input  busy, owner
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of the shared data memory.
// One transaction at a time: capture the winner, strobe memory for one
// cycle, wait MEM_LAT cycles, latch read data and pulse ack to the owner.
// Ties are broken by a priority bit that flips to the other port after
// every completed transaction.
module dmem_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int MEM_LAT    = 1,   // 1..15
    parameter int CORE_FIRST = 1
) (
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    // prio = 0 lets C win a tie, prio = 1 lets D win.
    localparam logic       PRIO_RST = (CORE_FIRST == 0);
    localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT - 1);

    state_t        state_q, state_d;
    logic          prio_q;
    logic          owner_q;      // 0 = C, 1 = D
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] c_rdata_q;
    logic [DW-1:0] d_rdata_q;
    logic [3:0]    lat_q;
    logic          any_req;
    logic          pick_d;

    assign any_req = bus.c_req || bus.d_req;
    assign pick_d  = bus.d_req && (!bus.c_req || prio_q);

    // State register
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state and per-state strobes
    always_comb begin
        // NOTE: every output of this block gets a default first; any path
        // that skips an assignment would otherwise infer a latch.
        state_d   = state_q;
        bus.m_en  = 1'b0;
        bus.m_we  = 1'b0;
        bus.c_ack = 1'b0;
        bus.d_ack = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (any_req) state_d = S_ISSUE;
            end
            S_ISSUE: begin
                bus.m_en = 1'b1;
                bus.m_we = we_q;
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                if (lat_q == 4'd0) state_d = S_RESP;
            end
            S_RESP: begin
                bus.c_ack = !owner_q;
                bus.d_ack = owner_q;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Request capture, latency count, read-data latch and priority update
    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q    <= PRIO_RST;
            owner_q   <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            lat_q     <= 4'd0;
            c_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (any_req) begin
                        owner_q <= pick_d;
                        we_q    <= pick_d ? bus.d_we    : bus.c_we;
                        addr_q  <= pick_d ? bus.d_addr  : bus.c_addr;
                        wdata_q <= pick_d ? bus.d_wdata : bus.c_wdata;
                    end
                end
                S_ISSUE: lat_q <= LAT_LOAD;
                S_WAIT: begin
                    if (lat_q != 4'd0) begin
                        lat_q <= lat_q - 4'd1;
                    end else if (!we_q) begin
                        if (owner_q) d_rdata_q <= bus.m_rdata;
                        else         c_rdata_q <= bus.m_rdata;
                    end
                end
                S_RESP: prio_q <= !owner_q;
                default: ;
            endcase
        end
    end

    assign bus.m_addr  = addr_q;
    assign bus.m_wdata = wdata_q;
    assign bus.c_rdata = c_rdata_q;
    assign bus.d_rdata = d_rdata_q;
    assign bus.busy    = (state_q != S_IDLE);
    assign bus.owner   = owner_q;
    assign bus.c_stall = bus.c_req && !bus.c_ack;
endmodule
